// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared hazard-unit definitions: load MemRead code, stall FSM encoding and stall-counter width.
// Also used by the forwarding unit, so keep it free of controller-specific logic.
package hazard_pkg;

  localparam logic [1:0] MEMREAD_LOAD = 2'b01;
  localparam int         LAT_W        = 4;

  typedef logic [0:0] state_t;
  localparam state_t RUN   = 1'b0;
  localparam state_t STALL = 1'b1;

  function automatic logic is_load(input logic [1:0] mem_read);
    return mem_read == MEMREAD_LOAD;
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; master is the pipeline side, slave the controller.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);

  logic [1:0]            idex_mem_read;
  logic [REG_ADDR_W-1:0] idex_rd;
  logic [REG_ADDR_W-1:0] ifid_rs1;
  logic [REG_ADDR_W-1:0] ifid_rs2;
  logic                  ifid_use_rs1;
  logic                  ifid_use_rs2;
  logic                  ex_branch_taken;
  logic                  mem_wait;
  logic                  clr_stats;

  logic                  pc_write;
  logic                  ifid_write;
  logic                  idex_bubble;
  logic                  ifid_flush;
  logic                  freeze;
  logic                  lu_stall;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           ex_branch_taken, mem_wait, clr_stats,
    input  pc_write, ifid_write, idex_bubble, ifid_flush, freeze, lu_stall, stall_count
  );

  modport slave (
    input  idex_mem_read, idex_rd, ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           ex_branch_taken, mem_wait, clr_stats,
    output pc_write, ifid_write, idex_bubble, ifid_flush, freeze, lu_stall, stall_count
  );

endinterface

// File: rtl/hazard_stall_ctrl_lu_src_match.sv
// Combinational load-use compare of ID sources against the EX load destination.
// x0 and sources the ID instruction does not read never match.
module lu_src_match
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [1:0]            mem_read_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic                  use_rs1_i,
  input  logic                  use_rs2_i,
  output logic                  hit_o
);

  logic rd_live;
  logic rs1_hit;
  logic rs2_hit;

  assign rd_live = is_load(mem_read_i) && (rd_i != '0);
  assign rs1_hit = use_rs1_i && (rs1_i == rd_i);
  assign rs2_hit = use_rs2_i && (rs2_i == rd_i);
  assign hit_o   = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard/stall controller beside ID: branch flush > mem_wait freeze > load-use stall,
// stalling LOAD_LATENCY unfrozen cycles per hazard; all controls combinational, stall_count registered.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int LOAD_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic clk,
  input  logic rst,
  hazard_stall_ctrl_if.slave hz
);

  if (LOAD_LATENCY < 1 || LOAD_LATENCY > 15) begin : g_bad_latency
    $error("hazard_stall_ctrl: LOAD_LATENCY must be within 1..15");
  end

  localparam logic [LAT_W-1:0] CNT_RELOAD = LAT_W'(LOAD_LATENCY - 1);
  localparam logic [LAT_W-1:0] CNT_ONE    = LAT_W'(1);
  localparam bit               MULTI_CYC  = (LOAD_LATENCY > 1);

  state_t           state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic hit;
  logic pc_write;
  logic ifid_write;
  logic idex_bubble;
  logic ifid_flush;
  logic freeze;
  logic lu_stall;

  lu_src_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_lu_src_match (
    .mem_read_i(hz.idex_mem_read),
    .rd_i      (hz.idex_rd),
    .rs1_i     (hz.ifid_rs1),
    .rs2_i     (hz.ifid_rs2),
    .use_rs1_i (hz.ifid_use_rs1),
    .use_rs2_i (hz.ifid_use_rs2),
    .hit_o     (hit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    lu_stall    = 1'b0;

    if (rst) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (hz.ex_branch_taken) begin
      // The dependent instruction is on the wrong path; squash it and drop the stall.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      cnt_d       = '0;
    end else if (hz.mem_wait) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (state_q == STALL || hit) begin
      lu_stall    = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      if (state_q == STALL) begin
        if (cnt_q == CNT_ONE) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end else if (MULTI_CYC) begin
        state_d = STALL;
        cnt_d   = CNT_RELOAD;
      end
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (hz.clr_stats) begin
      stall_count_d = '0;
    end else if (lu_stall && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.idex_bubble = idex_bubble;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.freeze      = freeze;
  assign hz.lu_stall    = lu_stall;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: LAT=1, LAT=3 and a 4-bit-counter instance on shared stimulus.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1 = 1'b1, rst3 = 1'b1, rsts = 1'b1;

  logic [1:0] mr = 2'b00;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       u1 = 1'b0, u2 = 1'b0, br = 1'b0, mw = 1'b0, clr = 1'b0;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if1 ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if3 ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  ifs ();

  assign if1.idex_mem_read = mr;  assign if3.idex_mem_read = mr;  assign ifs.idex_mem_read = mr;
  assign if1.idex_rd = rd;        assign if3.idex_rd = rd;        assign ifs.idex_rd = rd;
  assign if1.ifid_rs1 = rs1;      assign if3.ifid_rs1 = rs1;      assign ifs.ifid_rs1 = rs1;
  assign if1.ifid_rs2 = rs2;      assign if3.ifid_rs2 = rs2;      assign ifs.ifid_rs2 = rs2;
  assign if1.ifid_use_rs1 = u1;   assign if3.ifid_use_rs1 = u1;   assign ifs.ifid_use_rs1 = u1;
  assign if1.ifid_use_rs2 = u2;   assign if3.ifid_use_rs2 = u2;   assign ifs.ifid_use_rs2 = u2;
  assign if1.ex_branch_taken = br; assign if3.ex_branch_taken = br; assign ifs.ex_branch_taken = br;
  assign if1.mem_wait = mw;       assign if3.mem_wait = mw;       assign ifs.mem_wait = mw;
  assign if1.clr_stats = clr;     assign if3.clr_stats = clr;     assign ifs.clr_stats = clr;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst1), .hz(if1));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(3), .CNT_W(16)) dut3 (.clk(clk), .rst(rst3), .hz(if3));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LATENCY(1), .CNT_W(4))  duts (.clk(clk), .rst(rsts), .hz(ifs));

  // {pc_write, ifid_write, idex_bubble, ifid_flush, freeze, lu_stall}
  logic [5:0] o1, o3, os;
  assign o1 = {if1.pc_write, if1.ifid_write, if1.idex_bubble, if1.ifid_flush, if1.freeze, if1.lu_stall};
  assign o3 = {if3.pc_write, if3.ifid_write, if3.idex_bubble, if3.ifid_flush, if3.freeze, if3.lu_stall};
  assign os = {ifs.pc_write, ifs.ifid_write, ifs.idex_bubble, ifs.ifid_flush, ifs.freeze, ifs.lu_stall};

  localparam logic [5:0] O_RUN   = 6'b110000;
  localparam logic [5:0] O_STALL = 6'b001001;
  localparam logic [5:0] O_FRZ   = 6'b000010;
  localparam logic [5:0] O_FLUSH = 6'b111100;

  typedef struct packed {
    logic [1:0] mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, br, mw;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   n_chk = 0, n_fail = 0;
  int   exp_cnt1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] m, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic a1, input logic a2,
                        input logic b, input logic w);
    mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2; br = b; mw = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b01, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL};
    tbl[1]  = '{2'b01, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, O_STALL};
    tbl[2]  = '{2'b01, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[3]  = '{2'b01, 5'd5, 5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[4]  = '{2'b10, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[5]  = '{2'b11, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[6]  = '{2'b00, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, O_RUN};
    tbl[7]  = '{2'b01, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, O_FRZ};
    tbl[8]  = '{2'b01, 5'd5, 5'd5, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, O_FLUSH};
    tbl[9]  = '{2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, O_FLUSH};
    tbl[10] = '{2'b00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, O_FRZ};
    tbl[11] = '{2'b01, 5'd9, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, O_STALL};

    // Reset: a live hazard on the inputs must not leak through while rst is high.
    set_in(2'b01, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    chk("rst_out1", 16'(o1), 16'(O_RUN));
    chk("rst_out3", 16'(o3), 16'(O_RUN));
    chk("rst_cnt1", if1.stall_count, 16'd0);
    chk("rst_cnts", 16'(ifs.stall_count), 16'd0);
    rst1 = 1'b0;
    set_in(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // LAT=1: single bubble for load x5 -> add rs1=x5.
    set_in(2'b01, 5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    #4 chk("t1_stall", 16'(o1), 16'(O_STALL));
    tick();
    chk("t1_cnt", if1.stall_count, 16'd1);
    set_in(2'b00, 5'd0, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    #4 chk("t1_resume", 16'(o1), 16'(O_RUN));
    tick();

    exp_cnt1 = 1;
    for (int i = 0; i < 12; i++) begin
      set_in(tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].br, tbl[i].mw);
      #4 chk($sformatf("vec%0d", i), 16'(o1), 16'(tbl[i].exp));
      if (tbl[i].exp[0]) exp_cnt1++;
      tick();
    end
    chk("tbl_cnt1", if1.stall_count, 16'(exp_cnt1));
    rst1 = 1'b1;

    // LAT=3: load x7, rs2=x7 -> three stall cycles.
    rst3 = 1'b0;
    set_in(2'b00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_in(2'b01, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      else        set_in(2'b00, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      #4 chk($sformatf("t2_c%0d", c), 16'(o3), 16'((c < 3) ? O_STALL : O_RUN));
      tick();
    end
    chk("t2_cnt", if3.stall_count, 16'd3);

    // Same hazard with a mem_wait pulse in the second cycle: four held cycles, three counted.
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_in(2'b01, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      else        set_in(2'b00, 5'd0, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, (c == 1));
      #4 chk($sformatf("t2w_c%0d", c), 16'(o3),
             16'((c == 1) ? O_FRZ : (c == 4) ? O_RUN : O_STALL));
      tick();
    end
    chk("t2w_cnt", if3.stall_count, 16'd6);

    // Branch taken in the second stall cycle aborts the stall.
    set_in(2'b01, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #4 chk("t4_c0", 16'(o3), 16'(O_STALL));
    tick();
    set_in(2'b00, 5'd0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    #4 chk("t4_flush", 16'(o3), 16'(O_FLUSH));
    tick();
    set_in(2'b00, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    #4 chk("t4_run", 16'(o3), 16'(O_RUN));
    tick();
    chk("t4_cnt", if3.stall_count, 16'd7);

    // Reset while in STALL returns to RUN with a cleared counter.
    set_in(2'b01, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #4 chk("t5_enter", 16'(o3), 16'(O_STALL));
    tick();
    set_in(2'b00, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst3 = 1'b1;
    #4 chk("t5_inrst", 16'(o3), 16'(O_RUN));
    tick();
    rst3 = 1'b0;
    #4 chk("t5_after", 16'(o3), 16'(O_RUN));
    chk("t5_cnt", if3.stall_count, 16'd0);
    tick();
    rst3 = 1'b1;

    // 4-bit counter: 2^4+5 stall cycles saturate at 15; clear wins over increment.
    rsts = 1'b0;
    set_in(2'b01, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    chk("t6_at15", 16'(ifs.stall_count), 16'd15);
    for (int i = 0; i < 6; i++) tick();
    chk("t6_sat", 16'(ifs.stall_count), 16'd15);
    chk("t6_still_stall", 16'(os), 16'(O_STALL));
    clr = 1'b1;
    tick();
    chk("t6_clr", 16'(ifs.stall_count), 16'd0);
    clr = 1'b0;
    tick();
    chk("t6_restart", 16'(ifs.stall_count), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
